// File: rtl/axi_lite_master_ptgen_if.sv
// AXI4-Lite bus bundle between the pattern generator and a slave.
// Address/data widths follow the master's parameters.
interface axi_lite_master_ptgen_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master_ptgen.sv
// AXI4-Lite pattern generator/checker: writes and/or reads back
// seed+i at base+i*stride, flags completion and counts failures.
module axi_lite_master_ptgen #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TXN_COUNT = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]
    C_TARGET_BASE_ADDR = 'h4000_0000,
  parameter logic [31:0] C_PATTERN_SEED = 32'hAA00_0000
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       INIT_AXI_TXN,
  input  logic [1:0] MODE,
  output logic       TXN_DONE,
  output logic       ERROR,
  output logic [7:0] ERR_COUNT,
  axi_lite_master_ptgen_if.master m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int IW = $clog2(C_TXN_COUNT + 1);
  localparam int SH = $clog2(DW / 8);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] idx;
  logic [1:0]    mode_q;
  logic [1:0]    mode_n;
  logic          init_q;
  logic          busy;
  logic          aw_done;
  logic          w_done;
  logic          awvalid;
  logic          wvalid;
  logic          bready;
  logic          arvalid;
  logic          rready;

  logic          init_edge;
  logic          start;
  logic          last;
  logic          aw_hs;
  logic          w_hs;
  logic          aw_ok;
  logic          w_ok;
  logic          b_fire;
  logic          r_fire;
  logic          fail;
  logic [AW-1:0] addr;
  logic [DW-1:0] pat;
  logic          unused_ok;

  assign addr = C_TARGET_BASE_ADDR + (AW'(idx) << SH);
  assign pat  = DW'(C_PATTERN_SEED) + DW'(idx);

  assign m_axi.awaddr  = addr;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = pat;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = addr;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;

  assign unused_ok = ^{m_axi.bresp[0], m_axi.rresp[0]};

  assign init_edge = INIT_AXI_TXN & ~init_q;
  assign start  = init_edge
                & (state == IDLE || state == DONE);
  assign mode_n = (MODE == 2'b11) ? 2'b00 : MODE;
  assign last   = (idx == IW'(C_TXN_COUNT - 1));
  assign aw_hs  = awvalid & m_axi.awready;
  assign w_hs   = wvalid & m_axi.wready;
  assign aw_ok  = aw_done | aw_hs;
  assign w_ok   = w_done | w_hs;
  assign b_fire = bready & m_axi.bvalid;
  assign r_fire = rready & m_axi.rvalid;
  assign fail   = (b_fire & m_axi.bresp[1])
                | (r_fire & (m_axi.rresp[1]
                  | (m_axi.rdata != pat)));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (init_edge)
          state_n = (mode_n == 2'b10) ? READ : WRITE;
      end
      WRITE: begin
        if (b_fire && last)
          state_n = (mode_q == 2'b01) ? DONE : READ;
      end
      READ: begin
        if (r_fire && last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx       <= '0;
      mode_q    <= 2'b00;
      init_q    <= 1'b0;
      busy      <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      TXN_DONE  <= 1'b0;
      ERROR     <= 1'b0;
      ERR_COUNT <= 8'd0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (fail) begin
        ERROR <= 1'b1;
        if (ERR_COUNT != 8'hFF)
          ERR_COUNT <= ERR_COUNT + 8'd1;
      end
      if (start) begin
        idx       <= '0;
        mode_q    <= mode_n;
        busy      <= 1'b0;
        TXN_DONE  <= 1'b0;
        ERROR     <= 1'b0;
        ERR_COUNT <= 8'd0;
      end else begin
        unique case (state)
          WRITE: begin
            // busy low marks the idle beat between writes
            if (!busy) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              busy    <= 1'b1;
            end else begin
              if (aw_hs) awvalid <= 1'b0;
              if (w_hs)  wvalid  <= 1'b0;
              aw_done <= aw_ok;
              w_done  <= w_ok;
              if (b_fire) begin
                bready <= 1'b0;
                busy   <= 1'b0;
                idx    <= last ? '0 : idx + 1'b1;
                if (last && mode_q == 2'b01)
                  TXN_DONE <= 1'b1;
              end else if (aw_ok && w_ok) begin
                bready <= 1'b1;
              end
            end
          end
          READ: begin
            if (!busy) begin
              arvalid <= 1'b1;
              busy    <= 1'b1;
            end else if (arvalid) begin
              if (m_axi.arready) begin
                arvalid <= 1'b0;
                rready  <= 1'b1;
              end
            end else if (r_fire) begin
              rready <= 1'b0;
              busy   <= 1'b0;
              idx    <= last ? '0 : idx + 1'b1;
              if (last) TXN_DONE <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_master_ptgen.sv
// Directed bench: memory slave with optional stalls and fault
// injection, run through each mode and the reset/restart cases.
module tb_axi_lite_master_ptgen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       done;
  logic       err;
  logic [7:0] ecnt;

  int tests = 0;
  int fails = 0;

  logic [3:0] aw_dly = 4'd0;
  logic       rnd_en = 1'b0;
  logic       berr_en = 1'b0;
  logic       cor_en = 1'b0;

  axi_lite_master_ptgen_if #(.AW(32), .DW(32)) bus ();

  axi_lite_master_ptgen dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .INIT_AXI_TXN(init),
    .MODE(mode),
    .TXN_DONE(done),
    .ERROR(err),
    .ERR_COUNT(ecnt),
    .m_axi(bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic [3:0]  aw_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] aw_a;
  logic [31:0] w_d;
  logic [31:0] ar_a;
  logic        r_pend;
  logic [1:0]  r_wait;
  int wr_cnt;
  int rd_cnt;
  int bad_addr;

  assign bus.awready = (aw_cnt >= aw_dly);
  assign bus.wready  = 1'b1;
  assign bus.arready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt     <= 4'd0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      r_pend     <= 1'b0;
      r_wait     <= 2'd0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rresp  <= 2'b00;
      bus.rdata  <= 32'd0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1;
        aw_a   <= bus.awaddr;
        aw_cnt <= 4'd0;
      end else if (bus.awvalid) begin
        aw_cnt <= aw_cnt + 4'd1;
      end
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1;
        w_d   <= bus.wdata;
      end
      if (aw_got && w_got && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= (berr_en && aw_a == 32'h4000_0008)
                    ? 2'b10 : 2'b00;
        mem[aw_a[5:2]] <= w_d;
        if (aw_a[31:4] != 28'h400_0000)
          bad_addr <= bad_addr + 1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        ar_a   <= bus.araddr;
        r_pend <= 1'b1;
        r_wait <= rnd_en ? 2'($urandom_range(0, 3)) : 2'd0;
        rd_cnt <= rd_cnt + 1;
      end else if (r_pend && !bus.rvalid) begin
        if (r_wait == 2'd0) begin
          bus.rvalid <= 1'b1;
          bus.rresp  <= 2'b00;
          bus.rdata  <= mem[ar_a[5:2]] ^
            {31'd0, cor_en && ar_a == 32'h4000_0004};
          r_pend <= 1'b0;
        end else begin
          r_wait <= r_wait - 2'd1;
        end
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  int viol;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_awv <= 1'b0;
      p_wv  <= 1'b0;
      p_arv <= 1'b0;
    end else begin
      viol <= viol
        + int'(p_awv && !p_awr && (!bus.awvalid
            || bus.awaddr != p_awa))
        + int'(p_wv && !p_wr && (!bus.wvalid
            || bus.wdata != p_wd))
        + int'(p_arv && !p_arr && (!bus.arvalid
            || bus.araddr != p_ara));
      p_awv <= bus.awvalid;
      p_awr <= bus.awready;
      p_awa <= bus.awaddr;
      p_wv  <= bus.wvalid;
      p_wr  <= bus.wready;
      p_wd  <= bus.wdata;
      p_arv <= bus.arvalid;
      p_arr <= bus.arready;
      p_ara <= bus.araddr;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (done) break;
    end
    #1;
    check(tag, 32'(done), 32'd1);
  endtask

  int w0, r0;

  initial begin
    wr_cnt   = 0;
    rd_cnt   = 0;
    bad_addr = 0;
    viol     = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_awvalid", 32'(bus.awvalid), 0);
    check("rst_wvalid", 32'(bus.wvalid), 0);
    check("rst_bready", 32'(bus.bready), 0);
    check("rst_arvalid", 32'(bus.arvalid), 0);
    check("rst_rready", 32'(bus.rready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ecnt", 32'(ecnt), 0);
    check("rst_addr", bus.awaddr, 32'h4000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // clean write + readback
    w0 = wr_cnt; r0 = rd_cnt;
    pulse(2'b00);
    check("start_clr", 32'(done), 0);
    wait_done("t1_done");
    check("t1_err", 32'(err), 0);
    check("t1_ecnt", 32'(ecnt), 0);
    check("t1_wr", 32'(wr_cnt - w0), 4);
    check("t1_rd", 32'(rd_cnt - r0), 4);
    check("t1_mem0", mem[0], 32'hAA00_0000);
    check("t1_mem1", mem[1], 32'hAA00_0001);
    check("t1_mem2", mem[2], 32'hAA00_0002);
    check("t1_mem3", mem[3], 32'hAA00_0003);
    check("t1_bad", 32'(bad_addr), 0);

    // write-only with BRESP error on txn 2
    berr_en = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    pulse(2'b01);
    wait_done("t2_done");
    check("t2_err", 32'(err), 1);
    check("t2_ecnt", 32'(ecnt), 1);
    check("t2_wr", 32'(wr_cnt - w0), 4);
    check("t2_rd", 32'(rd_cnt - r0), 0);
    berr_en = 1'b0;

    // read-check against memory already holding the pattern
    w0 = wr_cnt; r0 = rd_cnt;
    pulse(2'b10);
    wait_done("t3_done");
    check("t3_err", 32'(err), 0);
    check("t3_ecnt", 32'(ecnt), 0);
    check("t3_wr", 32'(wr_cnt - w0), 0);
    check("t3_rd", 32'(rd_cnt - r0), 4);

    // corrupted read data at 0x40000004
    cor_en = 1'b1;
    pulse(2'b00);
    wait_done("t4_done");
    check("t4_err", 32'(err), 1);
    check("t4_ecnt", 32'(ecnt), 1);
    cor_en = 1'b0;

    // second INIT mid-write is ignored; flags clear on start
    aw_dly = 4'd3;
    w0 = wr_cnt; r0 = rd_cnt;
    pulse(2'b00);
    check("t5_err_clr", 32'(err), 0);
    check("t5_ecnt_clr", 32'(ecnt), 0);
    @(negedge clk);
    check("t5_in_write", 32'(bus.awvalid), 1);
    pulse(2'b10);
    wait_done("t5_done");
    check("t5_wr", 32'(wr_cnt - w0), 4);
    check("t5_rd", 32'(rd_cnt - r0), 4);
    check("t5_err", 32'(err), 0);
    w0 = wr_cnt; r0 = rd_cnt;
    pulse(2'b11);
    check("t5b_clr", 32'(done), 0);
    wait_done("t5b_done");
    check("t5b_wr", 32'(wr_cnt - w0), 4);
    check("t5b_rd", 32'(rd_cnt - r0), 4);
    check("t5b_ecnt", 32'(ecnt), 0);

    // stalled AW plus random R latency
    rnd_en = 1'b1;
    mem[1] = 32'd0;
    pulse(2'b00);
    wait_done("t6_done");
    check("t6_err", 32'(err), 0);
    check("t6_ecnt", 32'(ecnt), 0);
    check("t6_mem1", mem[1], 32'hAA00_0001);
    check("t6_stable", 32'(viol), 0);
    aw_dly = 4'd0;
    rnd_en = 1'b0;

    // asynchronous reset in the read phase
    pulse(2'b00);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bus.arvalid || bus.rready) break;
    end
    #3;
    check("t7_in_read",
          32'(bus.arvalid | bus.rready), 1);
    rst_n = 1'b0;
    #1;
    check("t7_arvalid", 32'(bus.arvalid), 0);
    check("t7_rready", 32'(bus.rready), 0);
    check("t7_awvalid", 32'(bus.awvalid), 0);
    check("t7_bready", 32'(bus.bready), 0);
    check("t7_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse(2'b00);
    wait_done("t7_rerun");
    check("t7_err", 32'(err), 0);
    check("t7_ecnt", 32'(ecnt), 0);
    check("t7_bad", 32'(bad_addr), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_lite_master_ptgen.md
Name: axi_lite_master_ptgen

Overview:
Parametrised AXI4-Lite master pattern generator/checker for bring-up of slave IP. One INIT pulse launches C_TXN_COUNT transactions against a slave at C_TARGET_BASE_ADDR, in write-then-readback, write-only or read-check mode. Completion is flagged, a sticky error is raised and mismatches are counted. Sits in the block design between a test controller or testbench and an AXI-Lite slave or VIP.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, address width.
C_M_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
C_TXN_COUNT, 4, transactions per phase; 1..256.
C_TARGET_BASE_ADDR, 32'h40000000, first address; stride is C_M_AXI_DATA_WIDTH/8.
C_PATTERN_SEED, 32'hAA000000, pattern base, zero-extended to data width.

Ports:
ACLK in 1 clock; all logic on the rising edge.
ARESETN in 1 asynchronous active-low reset.
INIT_AXI_TXN in 1 start; the rising edge is detected internally.
MODE in 2 00 write+readback, 01 write only, 10 read check, 11 reserved (treated as 00); sampled at start.
TXN_DONE out 1 run complete; level.
ERROR out 1 sticky error for the current run.
ERR_COUNT out 8 count of failed transactions; saturates at 255.
M_AXI_AWADDR out ADDR write address.
M_AXI_AWVALID out 1 write address valid.
M_AXI_AWREADY in 1 write address ready.
M_AXI_WDATA out DATA write data.
M_AXI_WSTRB out DATA/8 write strobe; all ones.
M_AXI_WVALID out 1 write data valid.
M_AXI_WREADY in 1 write data ready.
M_AXI_BRESP in 2 write response.
M_AXI_BVALID in 1 write response valid.
M_AXI_BREADY out 1 write response ready.
M_AXI_ARADDR out ADDR read address.
M_AXI_ARVALID out 1 read address valid.
M_AXI_ARREADY in 1 read address ready.
M_AXI_RDATA in DATA read data.
M_AXI_RRESP in 2 read response.
M_AXI_RVALID in 1 read data valid.
M_AXI_RREADY out 1 read data ready.

Behaviour:
- Reset: all VALID/READY outputs 0, TXN_DONE 0, ERROR 0, ERR_COUNT 0, FSM in IDLE, index 0. Reset mid-transfer drops VALIDs asynchronously; no completion of the transfer is attempted.
- FSM states: IDLE, WRITE, READ, DONE. An INIT edge in IDLE or DONE clears TXN_DONE, ERROR, ERR_COUNT and index, latches MODE, then moves to WRITE (modes 00, 01) or READ (mode 10). INIT edges in WRITE or READ are ignored.
- Transaction i: address = C_TARGET_BASE_ADDR + i*stride; pattern = C_PATTERN_SEED + i.
- WRITE: AWVALID and WVALID assert together in the cycle after entry or after the previous B. Each drops independently the cycle after its own handshake. BREADY asserts once both handshakes are done and stays high until BVALID. Exactly one write is outstanding at a time.
- BRESP[1]=1 fails the transaction.
- After the last B: mode 00 goes to READ with index reset to 0; mode 01 goes to DONE.
- READ: ARVALID holds until ARREADY; RREADY then holds until RVALID. A transaction fails on RRESP[1]=1 or RDATA != pattern(i). The last R goes to DONE.
- VALID stability: VALID and its payload never change while VALID=1 and READY=0.
- A handshake arriving in the same cycle VALID rises is legal; the next transaction may issue the following cycle. Minimum 3 cycles per write and 3 per read against an always-ready slave.
- Each failed transaction sets ERROR and increments ERR_COUNT once; a write and a read of the same index can each count.
- DONE: TXN_DONE=1, outputs hold until the next INIT edge or reset.
- Index counter width is clog2(C_TXN_COUNT+1) and wraps to 0 between phases.

Test Plan:
- Always-ready OKAY memory slave, MODE=00, default parameters -> writes AA000000..AA000003 at 40000000..4000000C, reads match, TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- Slave returns BRESP=2'b10 on transaction 2, MODE=01 -> ERROR=1, ERR_COUNT=1, no reads issued.
- Slave memory bit 0 corrupted at 40000004, MODE=00 -> ERR_COUNT=1, ERROR=1, TXN_DONE=1.
- Random backpressure: AWREADY delayed 3 cycles, WREADY 0 cycles, RVALID random -> VALIDs and payloads stable while stalled, final result passes.
- INIT pulse during WRITE, then a second INIT after DONE -> first ignored; second clears flags and reruns identically.
- ARESETN low mid-READ -> all outputs 0 immediately; new INIT after release completes cleanly.
